// File: rtl/display_pkg.sv
// Shared seven-segment constants for the multiplexed display driver.
// Patterns are active-high, bit order {p,G,F,E,D,C,B,A}.
package display_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_P = 7;

  localparam logic [7:0] DISP_OFF = 8'h00;

  // Hex glyphs 0-F in gfedcba form; b and d are lower-case to stay distinct from 8 and 0.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble plus decimal point to active-high segment pattern.
module seg_hex_decode
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] pattern
);

  always_comb begin
    pattern              = DISP_OFF;
    pattern[SEG_G:SEG_A] = HEX_SEG[nibble];
    pattern[SEG_P]       = dp;
  end

endmodule

// File: rtl/display_mux.sv
// Time-multiplexed seven-segment scanner with guard interval, PWM dimming
// and frame-synchronous loading of the displayed value.
module display_mux
  import display_pkg::*;
#(
  parameter int NUM_DIGITS         = 4,
  parameter int SLOT_CYCLES        = 100000,
  parameter int GUARD_CYCLES       = 1000,
  parameter int BRIGHT_W           = 4,
  parameter int ANODE_ACTIVE_LOW   = 1,
  parameter int CATHODE_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [7:0]              cathode,
  output logic                    frame_start
);

  localparam int SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [NUM_DIGITS-1:0] ANODE_OFF =
    (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [7:0] CATHODE_OFF =
    (CATHODE_ACTIVE_LOW != 0) ? ~DISP_OFF : DISP_OFF;

  logic [SLOT_W-1:0]       slot_cnt;
  logic [DIG_W-1:0]        digit_idx;
  logic [BRIGHT_W-1:0]     pwm_cnt;

  logic [4*NUM_DIGITS-1:0] pend_digits, act_digits;
  logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
  logic [NUM_DIGITS-1:0]   pend_blank, act_blank;

  logic                    slot_last;
  logic                    frame_end;
  logic [3:0]              cur_nibble;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   onehot;
  logic                    on_pwm;
  logic                    drive;
  logic [7:0]              pattern;
  logic [NUM_DIGITS-1:0]   anode_hi;
  logic [7:0]              cathode_hi;

  assign slot_last = (slot_cnt == SLOT_W'(SLOT_CYCLES - 1));
  assign frame_end = slot_last && (digit_idx == DIG_W'(NUM_DIGITS - 1));

  always_comb begin
    cur_nibble = 4'h0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b1;
    onehot     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == DIG_W'(i)) begin
        cur_nibble = act_digits[4*i +: 4];
        cur_dp     = act_dp[i];
        cur_blank  = act_blank[i];
        onehot[i]  = 1'b1;
      end
    end
  end

  seg_hex_decode u_decode (
    .nibble  (cur_nibble),
    .dp      (cur_dp),
    .pattern (pattern)
  );

  // Dark during the guard window so segments settle before the next anode turns on.
  assign on_pwm     = (&brightness) || (pwm_cnt < brightness);
  assign drive      = (slot_cnt >= SLOT_W'(GUARD_CYCLES)) && on_pwm && !cur_blank;
  assign anode_hi   = drive ? onehot : '0;
  assign cathode_hi = drive ? pattern : DISP_OFF;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt    <= '0;
      digit_idx   <= '0;
      pwm_cnt     <= '0;
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_blank  <= '1;
      act_digits  <= '0;
      act_dp      <= '0;
      act_blank   <= '1;
      anode       <= ANODE_OFF;
      cathode     <= CATHODE_OFF;
      frame_start <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;

      if (slot_last) begin
        slot_cnt  <= '0;
        digit_idx <= (digit_idx == DIG_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end

      if (load) begin
        pend_digits <= digits;
        pend_dp     <= dp;
        pend_blank  <= blank;
      end

      // A load landing on the boundary itself must not be lost for a whole frame.
      if (frame_end) begin
        act_digits <= load ? digits : pend_digits;
        act_dp     <= load ? dp     : pend_dp;
        act_blank  <= load ? blank  : pend_blank;
      end

      frame_start <= frame_end;
      anode       <= (ANODE_ACTIVE_LOW != 0)   ? ~anode_hi   : anode_hi;
      cathode     <= (CATHODE_ACTIVE_LOW != 0) ? ~cathode_hi : cathode_hi;
    end
  end

endmodule

// File: doc/display_mux.md
Name: display_mux

Overview:
- Parametrised time-multiplexed seven-segment driver for NUM_DIGITS common-anode or common-cathode digits.
- Extends the fixed 4-digit, decimal-only scanner with:
  - full hex decode (0-F)
  - per-digit decimal point and blank
  - anti-ghosting guard interval
  - PWM brightness
  - tear-free frame-synchronous loading
- Sits between a PicoBlaze output-port register bank and the board's anode/cathode pins.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits (1..16).
- SLOT_CYCLES, 100000: clocks each digit owns per scan (1 ms at 100 MHz).
- GUARD_CYCLES, 1000: clocks at the start of each slot with all anodes off; legal range is 1 <= GUARD_CYCLES < SLOT_CYCLES.
- BRIGHT_W, 4: brightness word width.
- ANODE_ACTIVE_LOW, 1: 1 means an enabled anode drives 0.
- CATHODE_ACTIVE_LOW, 1: 1 means a lit segment drives 0.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- load  in  1  single-cycle strobe; captures digits/dp/blank into the pending registers.
- digits  in  4*NUM_DIGITS  hex nibble per digit; digit i is bits [4i+3:4i].
- dp  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- blank  in  NUM_DIGITS  1 = digit fully dark, including dp.
- brightness  in  BRIGHT_W  0 = dark, all-ones = 100 % duty; sampled live, not through load.
- anode  out  NUM_DIGITS  digit enables.
- cathode  out  8  segment drives, ordered {p,G,F,E,D,C,B,A}.
- frame_start  out  1  one-cycle pulse when digit 0's slot begins.

Behaviour:
- Reset (synchronous, active-high):
  - slot_cnt, digit_idx and pwm_cnt go to 0.
  - Pending and active digits/dp go to 0; pending and active blank go to all-ones.
  - anode = all inactive, cathode = all segments off, frame_start = 0.
  - Display stays dark until the first load is transferred.
  - Reset mid-slot aborts the scan immediately; there is no partial-frame completion.
- Slot counter:
  - slot_cnt counts 0..SLOT_CYCLES-1.
  - At SLOT_CYCLES-1 it wraps to 0 and digit_idx advances.
  - digit_idx wraps from NUM_DIGITS-1 to 0.
  - Scan order is 0,1,...,NUM_DIGITS-1 (digit 0 = rightmost).
- Frame boundary: the cycle where slot_cnt wraps and digit_idx wraps to 0.
  - Pending transfers to active on this cycle.
  - frame_start is registered high in the following cycle, aligned with slot_cnt==0, digit_idx==0.
- Load handling:
  - load captures into pending on any cycle.
  - load on the frame-boundary cycle bypasses: the new inputs go straight to active on that same cycle.
  - Multiple loads within a frame: the last one wins.
- PWM:
  - pwm_cnt is a free-running BRIGHT_W-bit counter that wraps.
  - on_pwm = (brightness == all-ones) || (pwm_cnt < brightness).
- Drive enable: drive = (slot_cnt >= GUARD_CYCLES) && on_pwm && !active_blank[digit_idx].
- Decode, internal active-high form gfedcba:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  - Bit 7 = active dp[digit_idx].
- Outputs:
  - When drive=1: anode has one-hot enable for digit_idx and cathode carries the decoded pattern.
  - When drive=0: all anodes are inactive and cathode is all-off.
  - Polarity is applied last, per the two *_ACTIVE_LOW parameters.
- Latency: anode, cathode and frame_start are registered and reflect counter state one cycle earlier.
- Glitch rule: anode must never show two enabled digits in any cycle, and must never be enabled while cathode is changing between digits. The guard interval guarantees the latter.

Decomposition:
- Shared package display_pkg holds:
  - the 16-entry hex-to-segment constant table
  - segment bit-position constants (SEG_A..SEG_G, SEG_P)
  - the DISP_OFF pattern
- One sub-module, seg_hex_decode: 4-bit nibble plus dp in, 8-bit active-high pattern out, purely combinational.
- Everything else (counters, shadow registers, PWM, polarity) lives in display_mux.

Test Plan:
All scenarios use sim params NUM_DIGITS=4, SLOT_CYCLES=16, GUARD_CYCLES=2, BRIGHT_W=2, both polarities active-low.
1. Reset then no load -> anode=4'hF and cathode=8'hFF permanently; frame_start pulses every 64 clocks.
2. Load digits=16'h3A71, dp=4'b0010, blank=0, brightness=3 -> after the next frame_start:
   - digit0 anode 4'b1110 with cathode 8'hF9 ("1")
   - digit1 anode 4'b1101 with cathode ~8'h87=8'h78 ("7"+dp)
   - digit2 anode 4'b1011 with cathode ~8'h77=8'h88 ("A")
   - digit3 anode 4'b0111 with cathode ~8'h4F=8'hB0 ("3")
   - each digit enabled for 14 of 16 clocks, with the first 2 dark.
3. brightness=1 with the same data -> within each enabled window, anode is active exactly 1 of every 4 clocks; brightness=0 -> anode stays 4'hF.
4. Load mid-frame (digit 2 slot) with digits=16'hFFFF -> digits 2,3 keep the old values for the rest of that frame; all digits show "F" (8'h8E) from the next frame_start.
5. load asserted on the frame-boundary cycle with digits=16'h0000 -> digit 0's first enabled window already shows "0" (8'hC0).
6. blank=4'b0100 -> digit 2's slot stays fully dark, including dp. Assert reset during digit 3's slot -> the next cycle has anode=4'hF, cathode=8'hFF and blank all-ones.
